branch_resolve_queue: RTL

- Execute-side producer of branch feedback for the branch predictor.
- Decode pushes each predicted conditional branch (pc, prediction, recovery target) into an in-order queue.
- Execute resolves the oldest entry with the actual outcome. The block emits one registered feedback record per resolved branch.
- On a mispredict it also raises a redirect to the recovery target and flushes all younger queued branches.

---
 rtl/branch_resolve_queue_if.sv | 30 +++
 rtl/branch_resolve_queue.sv | 110 +++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: decode push, execute resolve and feedback/redirect signals of branch_resolve_queue
interface branch_resolve_queue_if #(parameter int ADDR_WIDTH = 32, parameter int DEPTH = 4);
  logic                    i_push_valid;
  logic [ADDR_WIDTH-1:0]   i_push_pc;
  logic                    i_push_prediction;
  logic [ADDR_WIDTH-1:0]   i_push_recovery_target;
  logic                    o_push_ready;
  logic                    i_res_valid;
  logic                    i_res_outcome;
  logic                    o_fb_valid;
  logic [ADDR_WIDTH-1:0]   o_fb_pc;
  logic                    o_fb_prediction;
  logic                    o_fb_outcome;
  logic                    o_redirect_valid;
  logic [ADDR_WIDTH-1:0]   o_redirect_pc;
  logic [$clog2(DEPTH):0]  o_count;
  logic                    o_underflow;
  logic [31:0]             o_stat_total;
  logic [31:0]             o_stat_mispredict;
  modport master (
    output i_push_valid, i_push_pc, i_push_prediction, i_push_recovery_target, i_res_valid, i_res_outcome,
    input  o_push_ready, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome, o_redirect_valid, o_redirect_pc,
           o_count, o_underflow, o_stat_total, o_stat_mispredict
  );
  modport slave (
    input  i_push_valid, i_push_pc, i_push_prediction, i_push_recovery_target, i_res_valid, i_res_outcome,
    output o_push_ready, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome, o_redirect_valid, o_redirect_pc,
           o_count, o_underflow, o_stat_total, o_stat_mispredict
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches emitting predictor feedback and mispredict redirects.
// Defining BRANCH_RESOLVE_STATS_EN adds feedback and mispredict counters.
module branch_resolve_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, RECOVER} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]      pred_mem;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic                  fb_valid_q, fb_valid_d, fb_pred_q, fb_pred_d, fb_outcome_q, fb_outcome_d;
  logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d, redirect_pc_q, redirect_pc_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic                  run, full, empty, push_ready, push_fire, res_fire, mispredict;
  always_comb begin
    run        = state_q == RUN;
    full       = count_q == CW'(DEPTH);
    empty      = count_q == '0;
    push_ready = run && !full;
    push_fire  = bus.i_push_valid && push_ready;
    res_fire   = run && bus.i_res_valid && !empty;
    mispredict = res_fire && (pred_mem[rd_ptr_q] != bus.i_res_outcome);
    state_d          = mispredict ? RECOVER : RUN;
    underflow_d      = underflow_q || (run && bus.i_res_valid && empty);
    rd_ptr_d         = res_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // A flush empties the queue by collapsing the tail onto the new head
    wr_ptr_d         = mispredict ? rd_ptr_q + PW'(1) : push_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d          = mispredict ? '0 : count_q + CW'(push_fire) - CW'(res_fire);
    fb_valid_d       = res_fire;
    fb_pc_d          = res_fire ? pc_mem[rd_ptr_q] : fb_pc_q;
    fb_pred_d        = res_fire ? pred_mem[rd_ptr_q] : fb_pred_q;
    fb_outcome_d     = res_fire ? bus.i_res_outcome : fb_outcome_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? tgt_mem[rd_ptr_q] : redirect_pc_q;
  end
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[wr_ptr_q]   <= bus.i_push_pc;
      tgt_mem[wr_ptr_q]  <= bus.i_push_recovery_target;
      pred_mem[wr_ptr_q] <= bus.i_push_prediction;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      underflow_q      <= 1'b0;
      fb_valid_q       <= 1'b0;
      fb_pc_q          <= '0;
      fb_pred_q        <= 1'b0;
      fb_outcome_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      underflow_q      <= underflow_d;
      fb_valid_q       <= fb_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_pred_q        <= fb_pred_d;
      fb_outcome_q     <= fb_outcome_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_total_q, stat_total_d, stat_mispredict_q, stat_mispredict_d;
  always_comb begin
    stat_total_d      = stat_total_q + 32'(res_fire);
    stat_mispredict_d = stat_mispredict_q + 32'(mispredict);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q      <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_total_q      <= stat_total_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end
  assign bus.o_stat_total      = stat_total_q;
  assign bus.o_stat_mispredict = stat_mispredict_q;
`else
  assign bus.o_stat_total      = '0;
  assign bus.o_stat_mispredict = '0;
`endif
  assign bus.o_push_ready     = push_ready;
  assign bus.o_fb_valid       = fb_valid_q;
  assign bus.o_fb_pc          = fb_pc_q;
  assign bus.o_fb_prediction  = fb_pred_q;
  assign bus.o_fb_outcome     = fb_outcome_q;
  assign bus.o_redirect_valid = redirect_valid_q;
  assign bus.o_redirect_pc    = redirect_pc_q;
  assign bus.o_count          = count_q;
  assign bus.o_underflow      = underflow_q;
endmodule
